// File: rtl/vscale_dmem_bridge.sv
// rtl/vscale_dmem_bridge.sv - split-phase core dmem port to valid/ready request/response bus bridge
// Optional response watchdog compiled in with VSCALE_DMEM_TIMEOUT_EN.
module vscale_dmem_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_en,
  input  logic              dmem_wen,
  input  logic [2:0]        dmem_size,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata_delayed,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_wait,
  output logic              dmem_badmem_e,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_wen,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [3:0]        bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_rdata,
  input  logic              bus_resp_err
);

  typedef enum logic [2:0] {IDLE, DATA, REQ, RESP, DONE, ERR} state_t;

  state_t     state;
  logic       accept;
  logic       misaligned;
  logic [3:0] strb_next;
  logic       unused_size_msb;

  assign unused_size_msb = dmem_size[2];

  // Size encoding 3 is reserved; it is treated as a word access.
  always_comb begin
    accept     = dmem_en && (state == IDLE || state == DONE || state == ERR);
    misaligned = ((dmem_size[1:0] == 2'd1) && dmem_addr[0]) ||
                 (dmem_size[1] && (dmem_addr[1:0] != 2'b00));
    case (dmem_size[1:0])
      2'd0:    strb_next = 4'b0001 << dmem_addr[1:0];
      2'd1:    strb_next = 4'b0011 << dmem_addr[1:0];
      default: strb_next = 4'b1111;
    endcase
  end

`ifdef VSCALE_DMEM_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] tcount;
  logic              timeout_hit;

  assign timeout_hit = (tcount == TCNT_LAST);

  // DATA always precedes REQ, so clearing there restarts the count on REQ entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount <= '0;
    end else if (state == DATA) begin
      tcount <= '0;
    end else if (state == REQ || state == RESP) begin
      tcount <= tcount + TCNT_W'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dmem_rdata    <= '0;
      dmem_wait     <= 1'b0;
      dmem_badmem_e <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_wen   <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= 4'b0000;
    end else begin
      dmem_badmem_e <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          dmem_wait     <= 1'b0;
          bus_req_valid <= 1'b0;
          if (accept) begin
            bus_req_wen   <= dmem_wen;
            bus_req_addr  <= {dmem_addr[ADDR_W-1:2], 2'b00};
            bus_req_wstrb <= strb_next;
            if (misaligned) begin
              state         <= ERR;
              dmem_badmem_e <= 1'b1;
            end else begin
              state     <= DATA;
              dmem_wait <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (bus_req_wen) begin
            bus_req_wdata <= dmem_wdata_delayed;
          end
          bus_req_valid <= 1'b1;
          state         <= REQ;
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= RESP;
          end
`ifdef VSCALE_DMEM_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_req_valid <= 1'b0;
            dmem_wait     <= 1'b0;
            dmem_badmem_e <= 1'b1;
            state         <= ERR;
          end
`endif
        end
        RESP: begin
          if (bus_resp_valid) begin
            dmem_wait <= 1'b0;
            if (bus_resp_err) begin
              dmem_badmem_e <= 1'b1;
              state         <= ERR;
            end else begin
              if (!bus_req_wen) begin
                dmem_rdata <= bus_resp_rdata;
              end
              state <= DONE;
            end
          end
`ifdef VSCALE_DMEM_TIMEOUT_EN
          else if (timeout_hit) begin
            dmem_wait     <= 1'b0;
            dmem_badmem_e <= 1'b1;
            state         <= ERR;
          end
`endif
        end
        default: begin
          dmem_wait     <= 1'b0;
          bus_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// tb/tb_vscale_dmem_bridge.sv - directed table-driven bench for vscale_dmem_bridge
// Timeout sequence runs only when built with VSCALE_DMEM_TIMEOUT_EN.
module tb_vscale_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_en = 1'b0;
  logic        dmem_wen = 1'b0;
  logic [2:0]  dmem_size = 3'd0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata_delayed = 32'h0;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_req_wen;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_resp_rdata = 32'h0;
  logic        bus_resp_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  vscale_dmem_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dmem_en(dmem_en),
    .dmem_wen(dmem_wen),
    .dmem_size(dmem_size),
    .dmem_addr(dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata(dmem_rdata),
    .dmem_wait(dmem_wait),
    .dmem_badmem_e(dmem_badmem_e),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_req_wen(bus_req_wen),
    .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata),
    .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid),
    .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_err(bus_resp_err)
  );

  always @(posedge clk) begin
    if (bus_req_valid && bus_req_ready) hs_count <= hs_count + 1;
  end

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic        bad;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    dmem_en        = 1'b1;
    dmem_wen       = v.wen;
    dmem_size      = v.size;
    dmem_addr      = v.addr;
    bus_req_ready  = 1'b1;
    bus_resp_valid = 1'b0;
    chk($sformatf("v%0d_accept_wait", idx), 32'(dmem_wait), 32'd0);
    step();
    dmem_en            = 1'b0;
    dmem_wdata_delayed = v.wdata;
    if (v.bad) begin
      chk($sformatf("v%0d_badmem", idx), 32'(dmem_badmem_e), 32'd1);
      chk($sformatf("v%0d_bad_wait", idx), 32'(dmem_wait), 32'd0);
      chk($sformatf("v%0d_bad_valid", idx), 32'(bus_req_valid), 32'd0);
      chk($sformatf("v%0d_bad_rdata", idx), dmem_rdata, v.e_rdata);
      step();
      chk($sformatf("v%0d_bad_pulse_end", idx), 32'(dmem_badmem_e), 32'd0);
      chk($sformatf("v%0d_bad_no_valid", idx), 32'(bus_req_valid), 32'd0);
    end else begin
      chk($sformatf("v%0d_data_wait", idx), 32'(dmem_wait), 32'd1);
      chk($sformatf("v%0d_data_valid", idx), 32'(bus_req_valid), 32'd0);
      step();
      dmem_wdata_delayed = 32'h0BAD0BAD;
      chk($sformatf("v%0d_req_valid", idx), 32'(bus_req_valid), 32'd1);
      chk($sformatf("v%0d_req_wait", idx), 32'(dmem_wait), 32'd1);
      chk($sformatf("v%0d_req_addr", idx), bus_req_addr, v.e_addr);
      chk($sformatf("v%0d_req_wstrb", idx), 32'(bus_req_wstrb), 32'(v.e_strb));
      chk($sformatf("v%0d_req_wen", idx), 32'(bus_req_wen), 32'(v.wen));
      if (v.wen) chk($sformatf("v%0d_req_wdata", idx), bus_req_wdata, v.wdata);
      step();
      chk($sformatf("v%0d_resp_valid", idx), 32'(bus_req_valid), 32'd0);
      chk($sformatf("v%0d_resp_wait", idx), 32'(dmem_wait), 32'd1);
      bus_resp_valid = 1'b1;
      bus_resp_rdata = v.resp;
      bus_resp_err   = 1'b0;
      step();
      bus_resp_valid = 1'b0;
      chk($sformatf("v%0d_done_wait", idx), 32'(dmem_wait), 32'd0);
      chk($sformatf("v%0d_done_badmem", idx), 32'(dmem_badmem_e), 32'd0);
      chk($sformatf("v%0d_done_rdata", idx), dmem_rdata, v.e_rdata);
      step();
      chk($sformatf("v%0d_idle_wait", idx), 32'(dmem_wait), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'h100, 4'hF,    32'hDEADBEEF};
    vecs[1] = '{1'b1, 3'd0, 32'h203, 32'h000000AA, 32'hFFFFFFFF, 1'b0, 32'h200, 4'b1000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h12345678, 1'b0, 32'h100, 4'b1100, 32'h12345678};
    vecs[3] = '{1'b0, 3'd1, 32'h101, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0,    32'h12345678};
    vecs[4] = '{1'b1, 3'd2, 32'h0FE, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0,    32'h12345678};
    vecs[5] = '{1'b0, 3'd0, 32'h001, 32'h0,        32'hCAFEF00D, 1'b0, 32'h000, 4'b0010, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 3'd1, 32'h306, 32'hBEEF1234, 32'hFFFFFFFF, 1'b0, 32'h304, 4'b1100, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 3'd2, 32'h40C, 32'h55AA55AA, 32'h13579BDF, 1'b0, 32'h40C, 4'hF,    32'hCAFEF00D};
    vecs[8] = '{1'b0, 3'd5, 32'h042, 32'h0,        32'h0BADF00D, 1'b0, 32'h040, 4'b1100, 32'h0BADF00D};
    vecs[9] = '{1'b0, 3'd2, 32'h203, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0,    32'h0BADF00D};

    // Power-on reset
    #1 reset = 1'b1;
    #1;
    chk("rst_wait", 32'(dmem_wait), 32'd0);
    chk("rst_badmem", 32'(dmem_badmem_e), 32'd0);
    chk("rst_valid", 32'(bus_req_valid), 32'd0);
    chk("rst_rdata", dmem_rdata, 32'h0);
    chk("rst_wstrb", 32'(bus_req_wstrb), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    chk("hs_table", 32'(hs_count), 32'd7);

    // Store byte with three cycles of request backpressure
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'd0; dmem_addr = 32'h203;
    bus_req_ready = 1'b0;
    step();
    dmem_en = 1'b0; dmem_wdata_delayed = 32'h000000AA;
    chk("stall_data_wait", 32'(dmem_wait), 32'd1);
    step();
    dmem_wdata_delayed = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(bus_req_valid), 32'd1);
      chk($sformatf("stall%0d_addr", k), bus_req_addr, 32'h200);
      chk($sformatf("stall%0d_wstrb", k), 32'(bus_req_wstrb), 32'h8);
      chk($sformatf("stall%0d_wen", k), 32'(bus_req_wen), 32'd1);
      chk($sformatf("stall%0d_wdata", k), bus_req_wdata, 32'h000000AA);
      chk($sformatf("stall%0d_wait", k), 32'(dmem_wait), 32'd1);
      step();
    end
    chk("stall_still_valid", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    step();
    chk("stall_resp_valid", 32'(bus_req_valid), 32'd0);
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'h77777777;
    step();
    bus_resp_valid = 1'b0;
    chk("stall_done_wait", 32'(dmem_wait), 32'd0);
    chk("stall_done_rdata", dmem_rdata, 32'h0BADF00D);

    // Back-to-back load accepted in the store's DONE cycle
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h500;
    step();
    dmem_en = 1'b0;
    chk("b2b_data_wait", 32'(dmem_wait), 32'd1);
    chk("b2b_data_valid", 32'(bus_req_valid), 32'd0);
    step();
    chk("b2b_req_valid", 32'(bus_req_valid), 32'd1);
    chk("b2b_req_addr", bus_req_addr, 32'h500);
    chk("b2b_req_wen", 32'(bus_req_wen), 32'd0);
    chk("b2b_req_wstrb", 32'(bus_req_wstrb), 32'hF);
    step();
    chk("b2b_resp_valid", 32'(bus_req_valid), 32'd0);
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'h600DCAFE;
    step();
    bus_resp_valid = 1'b0;
    chk("b2b_done_wait", 32'(dmem_wait), 32'd0);
    chk("b2b_done_rdata", dmem_rdata, 32'h600DCAFE);
    chk("hs_b2b", 32'(hs_count), 32'd9);
    step();

    // Error response on a load
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h600;
    step();
    dmem_en = 1'b0;
    step();
    step();
    chk("err_resp_wait", 32'(dmem_wait), 32'd1);
    bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_rdata = 32'h11111111;
    step();
    bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
    chk("err_badmem", 32'(dmem_badmem_e), 32'd1);
    chk("err_wait", 32'(dmem_wait), 32'd0);
    chk("err_valid", 32'(bus_req_valid), 32'd0);
    chk("err_rdata_kept", dmem_rdata, 32'h600DCAFE);
    step();
    chk("err_pulse_end", 32'(dmem_badmem_e), 32'd0);

    // Asynchronous reset while waiting in RESP
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h700;
    step();
    dmem_en = 1'b0;
    step();
    step();
    chk("rresp_wait", 32'(dmem_wait), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rresp_wait0", 32'(dmem_wait), 32'd0);
    chk("rresp_badmem0", 32'(dmem_badmem_e), 32'd0);
    chk("rresp_valid0", 32'(bus_req_valid), 32'd0);
    chk("rresp_rdata0", dmem_rdata, 32'h0);
    chk("rresp_addr0", bus_req_addr, 32'h0);
    chk("rresp_wdata0", bus_req_wdata, 32'h0);
    chk("rresp_wen0", 32'(bus_req_wen), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'h22222222;
    step();
    bus_resp_valid = 1'b0;
    chk("rresp_stale_rdata", dmem_rdata, 32'h0);
    chk("rresp_stale_wait", 32'(dmem_wait), 32'd0);
    chk("hs_err", 32'(hs_count), 32'd11);

`ifdef VSCALE_DMEM_TIMEOUT_EN
    // Watchdog: ready never asserted, no response
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h800;
    bus_req_ready = 1'b0;
    step();
    dmem_en = 1'b0;
    step();
    chk("to_req_valid", 32'(bus_req_valid), 32'd1);
    for (int k = 0; k < 7; k++) step();
    chk("to_pre_valid", 32'(bus_req_valid), 32'd1);
    chk("to_pre_badmem", 32'(dmem_badmem_e), 32'd0);
    chk("to_pre_wait", 32'(dmem_wait), 32'd1);
    step();
    chk("to_badmem", 32'(dmem_badmem_e), 32'd1);
    chk("to_valid_drop", 32'(bus_req_valid), 32'd0);
    chk("to_wait", 32'(dmem_wait), 32'd0);
    step();
    chk("to_pulse_end", 32'(dmem_badmem_e), 32'd0);
    step();
    bus_resp_valid = 1'b1; bus_resp_rdata = 32'h99999999;
    step();
    bus_resp_valid = 1'b0;
    chk("to_late_rdata", dmem_rdata, 32'h0);
    chk("to_late_badmem", 32'(dmem_badmem_e), 32'd0);
    chk("to_late_wait", 32'(dmem_wait), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
